// File: rtl/rect_pkg.sv
// Shared types and constants for the rectangle layer scheduler: slot geometry,
// screen dimensions and scheduler state encoding.
package rect_pkg;

    localparam int SCREEN_W     = 96;
    localparam int SCREEN_H     = 64;
    localparam int FRAME_PIXELS = 6144;
    localparam int COORD_W      = 8;
    localparam int COLOR_W      = 16;
    localparam int PIX_IDX_W    = 13;

    // Colour is stored beside the geometry so the hit test only sees the fields it needs.
    typedef struct packed {
        logic               en;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] len;
        logic [COORD_W-1:0] hgt;
    } rect_geom_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_SWAP
    } sched_state_t;

endpackage

// File: rtl/rect_hit_unit.sv
// Combinational coverage test of one rectangle slot against a pixel coordinate.
module rect_hit_unit
    import rect_pkg::*;
(
    input  rect_geom_t         geom_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               hit_o
);

    // Ends are widened by one bit so x0+len past 255 clips instead of wrapping.
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    assign x_end = {1'b0, geom_i.x} + {1'b0, geom_i.len};
    assign y_end = {1'b0, geom_i.y} + {1'b0, geom_i.hgt};

    assign hit_o = geom_i.en
                 && (x_i >= geom_i.x) && ({1'b0, x_i} <= x_end)
                 && (y_i >= geom_i.y) && ({1'b0, y_i} <= y_end);

endmodule

// File: rtl/rect_layer_sched.sv
// Double-buffered rectangle table with a frame-synchronous swap and a two-stage
// hit-test pipeline producing the colour of the highest-priority covering slot.
module rect_layer_sched
    import rect_pkg::*;
#(
    parameter int                        N_RECT   = 8,
    parameter int                        COLOR_W  = rect_pkg::COLOR_W,
    parameter int                        SCREEN_W = rect_pkg::SCREEN_W,
    parameter int                        SCREEN_H = rect_pkg::SCREEN_H,
    parameter logic [COLOR_W-1:0]        BG_COLOR = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [$clog2(N_RECT)-1:0] wr_idx,
    input  logic                      wr_en,
    input  logic [7:0]                wr_x,
    input  logic [7:0]                wr_y,
    input  logic [7:0]                wr_len,
    input  logic [7:0]                wr_hgt,
    input  logic [COLOR_W-1:0]        wr_color,
    input  logic                      commit_valid,
    output logic                      commit_ready,
    input  logic [12:0]               pixel_index,
    output logic [COLOR_W-1:0]        pixel_data,
    output logic                      hit,
    output logic [$clog2(N_RECT)-1:0] hit_idx,
    output logic                      frame_swapped
);

    localparam int IDX_W = $clog2(N_RECT);
    localparam logic [PIX_IDX_W-1:0] LAST_PIXELS = PIX_IDX_W'(SCREEN_W * SCREEN_H);

    sched_state_t state_q, state_d;

    rect_geom_t         shadow_q       [N_RECT];
    rect_geom_t         active_q       [N_RECT];
    logic [COLOR_W-1:0] shadow_color_q [N_RECT];
    logic [COLOR_W-1:0] active_color_q [N_RECT];

    logic [PIX_IDX_W-1:0] idx_q, prev_idx_q;
    logic                 frame_start;
    logic                 wr_fire, commit_fire;

    assign wr_ready      = (state_q == ST_IDLE);
    assign commit_ready  = (state_q == ST_IDLE);
    assign frame_swapped = (state_q == ST_SWAP);
    assign wr_fire       = wr_valid && wr_ready;
    assign commit_fire   = commit_valid && commit_ready;
    assign frame_start   = (idx_q == '0) && (prev_idx_q != '0);

    always_comb begin
        // NOTE: defaults first; any path that skips an assignment would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (commit_fire) state_d = ST_PENDING;
            ST_PENDING: if (frame_start) state_d = ST_SWAP;
            ST_SWAP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: the tables are cleared on reset because an enabled stale slot would paint the screen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_RECT; i++) begin
                shadow_q[i]       <= '0;
                shadow_color_q[i] <= '0;
            end
        end else if (wr_fire) begin
            shadow_q[wr_idx]       <= '{en: wr_en, x: wr_x, y: wr_y, len: wr_len, hgt: wr_hgt};
            shadow_color_q[wr_idx] <= wr_color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_RECT; i++) begin
                active_q[i]       <= '0;
                active_color_q[i] <= '0;
            end
        end else if (state_q == ST_SWAP) begin
            active_q       <= shadow_q;
            active_color_q <= shadow_color_q;
        end
    end

    // Stage 1: capture the index; the all-ones reset value lets a first frame at 0 count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            prev_idx_q <= '1;
        end else begin
            idx_q      <= pixel_index;
            prev_idx_q <= idx_q;
        end
    end

    logic [COORD_W-1:0] pix_x, pix_y;
    logic               pix_oor;

    assign pix_x   = COORD_W'(idx_q % PIX_IDX_W'(SCREEN_W));
    assign pix_y   = COORD_W'(idx_q / PIX_IDX_W'(SCREEN_W));
    assign pix_oor = (idx_q >= LAST_PIXELS);

    // Stage 2: per-slot tests against the active table, then a lowest-index-wins encoder.
    logic [N_RECT-1:0] slot_hit;

    for (genvar g = 0; g < N_RECT; g++) begin : g_slot
        rect_hit_unit u_hit (
            .geom_i (active_q[g]),
            .x_i    (pix_x),
            .y_i    (pix_y),
            .hit_o  (slot_hit[g])
        );
    end

    logic               win_hit;
    logic [IDX_W-1:0]   win_idx;
    logic [COLOR_W-1:0] win_color;

    always_comb begin
        win_hit   = 1'b0;
        win_idx   = '0;
        win_color = BG_COLOR;
        if (!pix_oor) begin
            for (int i = N_RECT - 1; i >= 0; i--) begin
                if (slot_hit[i]) begin
                    win_hit   = 1'b1;
                    win_idx   = IDX_W'(i);
                    win_color = active_color_q[i];
                end
            end
        end
    end

    logic               hit_q;
    logic [IDX_W-1:0]   hit_idx_q;
    logic [COLOR_W-1:0] pixel_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q        <= 1'b0;
            hit_idx_q    <= '0;
            pixel_data_q <= BG_COLOR;
        end else begin
            hit_q        <= win_hit;
            hit_idx_q    <= win_idx;
            pixel_data_q <= win_color;
        end
    end

    assign hit        = hit_q;
    assign hit_idx    = hit_idx_q;
    assign pixel_data = pixel_data_q;

endmodule

// File: tb/tb_rect_layer_sched.sv
// Self-checking bench for rect_layer_sched against a table-level reference model.
module tb_rect_layer_sched;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_idx = '0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_x = '0, wr_y = '0, wr_len = '0, wr_hgt = '0;
    logic [15:0] wr_color = '0;
    logic        commit_valid = 1'b0;
    logic        commit_ready;
    logic [12:0] pixel_index = 13'd1;
    logic [15:0] pixel_data;
    logic        hit;
    logic [2:0]  hit_idx;
    logic        frame_swapped;

    int errors = 0;
    int checks = 0;

    rect_layer_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_idx        (wr_idx),
        .wr_en         (wr_en),
        .wr_x          (wr_x),
        .wr_y          (wr_y),
        .wr_len        (wr_len),
        .wr_hgt        (wr_hgt),
        .wr_color      (wr_color),
        .commit_valid  (commit_valid),
        .commit_ready  (commit_ready),
        .pixel_index   (pixel_index),
        .pixel_data    (pixel_data),
        .hit           (hit),
        .hit_idx       (hit_idx),
        .frame_swapped (frame_swapped)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          en;
        int          x, y, len, hgt;
        int unsigned color;
    } mrect_t;

    mrect_t m_sh [N];
    mrect_t m_act[N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int s = 0; s < N; s++) begin
            m_sh[s]  = '{en: 0, x: 0, y: 0, len: 0, hgt: 0, color: 0};
            m_act[s] = m_sh[s];
        end
    endtask

    // Expected {hit, hit_idx, pixel_data} for an index under the current active model table.
    function automatic logic [19:0] ref_out(int idx);
        int x, y;
        logic [2:0] s3;
        if (idx >= 96 * 64) return 20'h0;
        x = idx % 96;
        y = idx / 96;
        for (int s = 0; s < N; s++) begin
            if (m_act[s].en && x >= m_act[s].x && x <= m_act[s].x + m_act[s].len
                            && y >= m_act[s].y && y <= m_act[s].y + m_act[s].hgt) begin
                s3 = s[2:0];
                return {1'b1, s3, m_act[s].color[15:0]};
            end
        end
        return 20'h0;
    endfunction

    task automatic probe(int idx);
        pixel_index = idx[12:0];
        tick();
        tick();
    endtask

    // Write one slot in IDLE, optionally together with a commit; the model records the write.
    task automatic wr_slot(int slot, bit en, int x, int y, int len, int hgt, int unsigned color, bit with_commit);
        wr_valid = 1'b1; wr_idx = slot[2:0]; wr_en = en;
        wr_x = x[7:0]; wr_y = y[7:0]; wr_len = len[7:0]; wr_hgt = hgt[7:0]; wr_color = color[15:0];
        commit_valid = with_commit;
        tick();
        wr_valid = 1'b0;
        commit_valid = 1'b0;
        m_sh[slot] = '{en: en, x: x, y: y, len: len, hgt: hgt, color: color & 32'hFFFF};
    endtask

    task automatic do_commit();
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
    endtask

    // Produce one frame start and count swap pulses; readies must be back the cycle after a pulse.
    task automatic run_frame(int exp_swaps, string name);
        int seen = 0;
        bit chk_next = 0;
        pixel_index = 13'd1;
        tick();
        tick();
        pixel_index = 13'd0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (chk_next) begin
                checks++;
                if (wr_ready !== 1'b1 || commit_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_ready_after_swap: wr_ready=%b commit_ready=%b expected 1 1", name, wr_ready, commit_ready);
                end
                chk_next = 0;
            end
            if (frame_swapped === 1'b1) begin
                seen++;
                chk_next = 1;
                m_act = m_sh;
            end
        end
        checks++;
        if (seen != exp_swaps) begin
            errors++;
            $display("FAIL %s_swap_count: got %0d pulses expected %0d", name, seen, exp_swaps);
        end
    endtask

    task automatic check_pixel(int idx, string name);
        logic [19:0] exp, got;
        probe(idx);
        exp = ref_out(idx);
        got = {hit, hit_idx, pixel_data};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s idx=%0d: hit=%b hit_idx=%0d data=%h expected hit=%b hit_idx=%0d data=%h",
                     name, idx, got[19], got[18:16], got[15:0], exp[19], exp[18:16], exp[15:0]);
        end
    endtask

    task automatic apply_reset(string name);
        rst_n = 1'b0;
        wr_valid = 1'b0;
        commit_valid = 1'b0;
        #2;
        model_clear();
        checks++;
        if ({hit, hit_idx, pixel_data, frame_swapped} !== 21'h0) begin
            errors++;
            $display("FAIL %s_outputs: hit=%b hit_idx=%0d data=%h swapped=%b expected all 0",
                     name, hit, hit_idx, pixel_data, frame_swapped);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (wr_ready !== 1'b1 || commit_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: wr_ready=%b commit_ready=%b expected 1 1", name, wr_ready, commit_ready);
        end
    endtask

    task automatic test_reset();
        pixel_index = 13'd1;
        #3;
        apply_reset("reset");
    endtask

    task automatic test_empty_sweep();
        int bad = 0;
        for (int i = 0; i < 96 * 64 + 2; i++) begin
            pixel_index = (i < 96 * 64) ? i[12:0] : 13'd5;
            tick();
            checks++;
            if (hit !== 1'b0 || pixel_data !== 16'h0000 || frame_swapped !== 1'b0) begin
                errors++;
                if (bad < 5)
                    $display("FAIL empty_sweep cycle=%0d: hit=%b data=%h swapped=%b expected 0 0000 0",
                             i, hit, pixel_data, frame_swapped);
                bad++;
            end
        end
    endtask

    task automatic test_basic();
        wr_slot(2, 1, 5, 1, 10, 3, 32'hF800, 0);
        do_commit();
        run_frame(1, "basic");
        check_pixel(200, "basic_hit");
        check_pixel(112, "basic_miss_right");
        check_pixel(15 + 4 * 96, "basic_corner");
    endtask

    task automatic test_overlap();
        wr_slot(0, 1, 0, 0, 95, 63, 32'h001F, 0);
        wr_slot(1, 1, 10, 10, 5, 5, 32'h07E0, 0);
        do_commit();
        run_frame(1, "overlap");
        check_pixel(970, "overlap_slot0_wins");
        wr_slot(0, 0, 0, 0, 95, 63, 32'h001F, 0);
        do_commit();
        run_frame(1, "overlap_dis");
        check_pixel(970, "overlap_slot1_after_disable");
        check_pixel(16 + 10 * 96, "overlap_slot1_right_miss");
    endtask

    task automatic test_pending();
        pixel_index = 13'd1970;
        tick();
        wr_slot(3, 1, 48, 18, 4, 4, 32'hAAAA, 1);
        checks++;
        if (wr_ready !== 1'b0 || commit_ready !== 1'b0) begin
            errors++;
            $display("FAIL pending_ready: wr_ready=%b commit_ready=%b expected 0 0", wr_ready, commit_ready);
        end
        // Rejected write: slot 0 would win at 1970 if it landed.
        wr_valid = 1'b1; wr_idx = 3'd0; wr_en = 1'b1;
        wr_x = 8'd48; wr_y = 8'd18; wr_len = 8'd4; wr_hgt = 8'd4; wr_color = 16'h1234;
        tick(); tick(); tick();
        wr_valid = 1'b0;
        check_pixel(1970, "pending_old_table");
        run_frame(1, "pending");
        check_pixel(1970, "pending_new_table");
    endtask

    task automatic test_edge();
        wr_slot(4, 1, 90, 60, 20, 20, 32'h5555, 0);
        wr_slot(5, 1, 30, 30, 0, 0, 32'hC0DE, 0);
        do_commit();
        run_frame(1, "edge");
        check_pixel(6143, "edge_last_pixel");
        check_pixel(6200, "edge_out_of_range");
        check_pixel(6144, "edge_first_oor");
        check_pixel(30 + 30 * 96, "single_pixel_hit");
        check_pixel(31 + 30 * 96, "single_pixel_right");
        check_pixel(30 + 31 * 96, "single_pixel_below");
    endtask

    task automatic test_random();
        for (int s = 0; s < N; s++)
            wr_slot(s, $urandom_range(0, 3) != 0, $urandom_range(0, 100), $urandom_range(0, 70),
                    $urandom_range(0, 30), $urandom_range(0, 20), $urandom & 32'hFFFF, 0);
        do_commit();
        run_frame(1, "random");
        for (int k = 0; k < 40; k++)
            check_pixel($urandom_range(1, 6300), "random");
    endtask

    task automatic test_reset_pending();
        wr_slot(0, 1, 20, 20, 3, 3, 32'hBEEF, 0);
        do_commit();
        run_frame(1, "pre_reset");
        check_pixel(21 + 21 * 96, "pre_reset_hit");
        wr_slot(0, 1, 40, 40, 3, 3, 32'h7777, 1);
        apply_reset("reset_pending");
        run_frame(0, "reset_pending");
        check_pixel(21 + 21 * 96, "reset_pending_cleared");
    endtask

    initial begin
        model_clear();
        test_reset();
        test_empty_sweep();
        test_basic();
        test_overlap();
        test_pending();
        test_edge();
        test_random();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rect_layer_sched.md
Name: rect_layer_sched

Overview:
- Scheduler and compositor for rectangle primitives on the 96x64 OLED.
- Game logic writes up to N_RECT rectangle descriptors (health bars, hitboxes, menus) into a shadow table through a valid/ready handshake.
- A commit request swaps the shadow table into the active table at the next frame start, so frames never tear.
- Every cycle, the active table is hit-tested against the OLED driver's pixel_index, and the block outputs the colour of the highest-priority rectangle hit.

Parameters:
- N_RECT, 8, number of rectangle slots (power of 2, 2..16); slot 0 has the highest priority.
- COLOR_W, 16, pixel colour width (RGB565).
- SCREEN_W, 96, pixels per row.
- SCREEN_H, 64, rows per frame.
- BG_COLOR, 16'h0000, colour output when no rectangle is hit.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  descriptor write request.
- wr_ready  out  1  shadow table accepts a write.
- wr_idx  in  $clog2(N_RECT)  slot to write.
- wr_en  in  1  slot enable bit.
- wr_x  in  8  X start.
- wr_y  in  8  Y start.
- wr_len  in  8  X extent; inclusive, so the right edge is x0+len.
- wr_hgt  in  8  Y extent; inclusive.
- wr_color  in  COLOR_W  slot colour.
- commit_valid  in  1  request a shadow-to-active swap.
- commit_ready  out  1  commit accepted this cycle when high with commit_valid.
- pixel_index  in  13  current OLED pixel index from the display driver.
- pixel_data  out  COLOR_W  composited colour.
- hit  out  1  some enabled rectangle covers the pixel.
- hit_idx  out  $clog2(N_RECT)  winning slot; 0 when hit=0.
- frame_swapped  out  1  one-cycle pulse when a swap occurs.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All shadow and active slots are disabled with zero fields.
  - State is IDLE.
  - pixel_data=BG_COLOR, hit=0, hit_idx=0, frame_swapped=0.
  - wr_ready=1 and commit_ready=1 once reset releases.
  - Reset mid-frame or mid-pending drops any pending swap.
- State machine:
  - IDLE: wr_ready=1 and commit_ready=1. A write handshake updates the addressed shadow slot on the clock edge. A commit handshake moves to PENDING.
  - PENDING: wr_ready=0 and commit_ready=0, so the shadow table is frozen. On a frame-start event, go to SWAP.
  - SWAP: lasts one cycle. The whole active table is copied from the shadow table, frame_swapped=1, then return to IDLE. The shadow table keeps its contents, so later writes are incremental.
- Simultaneous write and commit in IDLE: both are accepted. The write lands in the shadow table and is included in the swap.
- Frame-start event:
  - Fires when registered pixel_index == 0 and the previous registered value != 0.
  - The previous-index register resets to 13'h1FFF, so a first frame starting at index 0 is detected.
  - A frame start in the same cycle a commit is accepted is not used; the swap waits for the next frame start.
- Hit-test pipeline, 2-cycle latency from a pixel_index change to the outputs:
  - Stage 1: register pixel_index. Compute x = idx mod SCREEN_W and y = idx div SCREEN_W (8-bit each). Flag out-of-range when idx >= SCREEN_W*SCREEN_H.
  - Stage 2: for each enabled active slot, compute the bounds in 9 bits so x0+len does not wrap. Hit condition is x0 <= x <= x0+len and y0 <= y <= y0+hgt. A priority encoder selects the lowest hitting slot, and the outputs are registered.
  - Out-of-range index: hit=0, pixel_data=BG_COLOR.
- A swap takes effect for stage-2 evaluations starting the cycle after SWAP. Pixels already in flight finish with the old table.
- Rectangles extending past the screen are clipped implicitly: there is no wrap, and bounds above 95/63 simply never match beyond the edge.
- A zero extent (len=0, hgt=0) covers exactly one pixel.

Decomposition:
- Shared package rect_pkg holds:
  - descriptor struct fields and widths (8-bit coordinates, COLOR_W colour, enable);
  - SCREEN_W, SCREEN_H and the frame-pixel constant 6144;
  - state encoding IDLE/PENDING/SWAP.
- Sub-module rect_hit_unit: one registered-free combinational slot test (descriptor plus x, y in, hit out). It is instantiated N_RECT times inside the stage-2 generate loop.
- Index-to-XY conversion stays inline in stage 1.

Test Plan:
- Reset, then sweep pixel_index 0..6143 -> hit=0 and pixel_data=16'h0000 everywhere; frame_swapped never pulses.
- Write slot 2 {en=1, x=5, y=1, len=10, hgt=3, color=16'hF800}, commit, let pixel_index wrap to 0, then drive 200 (x=8, y=2) -> frame_swapped pulses once, and 2 cycles later hit=1, hit_idx=2, pixel_data=16'hF800. Index 112 (x=16, y=1) -> hit=0.
- Overlap: slot 0 {x=0, y=0, len=95, hgt=63, 16'h001F}, slot 1 {x=10, y=10, len=5, hgt=5, 16'h07E0} -> pixel 970 (x=10, y=10) gives hit_idx=0 and 16'h001F; disabling slot 0 then gives hit_idx=1 and 16'h07E0.
- Commit accepted, then write attempted before the frame wraps -> wr_ready=0 and commit_ready=0; the active table is unchanged until the swap; both ready signals are back to 1 the cycle after frame_swapped.
- Edge and clip: slot {x=90, y=60, len=20, hgt=20} -> pixel 6143 (x=95, y=63) hits; pixel_index 6200 -> hit=0, BG_COLOR.
- Assert rst_n=0 while PENDING -> outputs return to reset values immediately; the subsequent frame start produces no frame_swapped.
